// File: rtl/mul_pkg.sv
// Shared types and defaults for the sequential shift-add multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } mul_state_t;

  localparam int MUL_N_DEFAULT = 16;

  function automatic int cnt_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mul_seq_ctrl_if.sv
// Request/response bundle between the core sequencer and mul_seq_ctrl.
interface mul_seq_ctrl_if
  import mul_pkg::*;
#(
  parameter int N = MUL_N_DEFAULT
);

  logic           req_valid;
  logic           req_ready;
  logic [N-1:0]   rs1;
  logic [N-1:0]   rs2;
  logic           kill;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [2*N-1:0] mul_rd;
  logic           busy;

  modport master (
    output req_valid,
    output rs1,
    output rs2,
    output kill,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  mul_rd,
    input  busy
  );

  modport slave (
    input  req_valid,
    input  rs1,
    input  rs2,
    input  kill,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output mul_rd,
    output busy
  );

endinterface

// File: rtl/mul_seq_adder.sv
// Single W-bit adder shared across all iterations of the multiplier.
module mul_seq_adder #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/mul_seq_ctrl.sv
// Shift-add multiplier controller: one multiplier bit per clock.
// Optional early termination: define MUL_SEQ_EARLY_TERM_EN.
module mul_seq_ctrl
  import mul_pkg::*;
#(
  parameter int N = MUL_N_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  mul_seq_ctrl_if.slave bus
);

  localparam int W  = 2 * N;
  localparam int CW = cnt_w(N);

  mul_state_t    state_q, state_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  mcand_q, mcand_d;
  logic [N-1:0]  mplier_q, mplier_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_ready_q, req_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          busy_q, busy_d;

  logic [W-1:0]  addend;
  logic [W-1:0]  sum;
  logic          last;

  assign addend = mplier_q[0] ? mcand_q : '0;

  mul_seq_adder #(
    .W(W)
  ) u_add (
    .a  (acc_q),
    .b  (addend),
    .sum(sum)
  );

`ifdef MUL_SEQ_EARLY_TERM_EN
  // Stop once no set multiplier bits remain after this shift.
  assign last = (cnt_q == CW'(N - 1)) ||
                ((mplier_q >> 1) == '0);
`else
  assign last = (cnt_q == CW'(N - 1));
`endif

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          state_d  = RUN;
          mcand_d  = W'(bus.rs1);
          mplier_d = bus.rs2;
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      RUN: begin
        if (bus.kill) begin
          state_d = IDLE;
        end else begin
          acc_d    = sum;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
          if (last) state_d = DONE;
        end
      end
      DONE: begin
        // kill takes priority; either way the product is released.
        if (bus.kill || bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.busy      = busy_q;
  assign bus.mul_rd    = acc_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Scoreboard bench for mul_seq_ctrl with directed operand vectors.
module tb_mul_seq_ctrl;
  import mul_pkg::*;

  localparam int N = 16;
`ifdef MUL_SEQ_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif

  typedef struct {
    logic [2*N-1:0] prod;
    int             lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mul_seq_ctrl_if #(.N(N)) bus ();

  mul_seq_ctrl #(
    .N(N)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   tests   = 0;
  int   fails   = 0;
  int   cyc     = 0;
  int   acc_cyc = 0;
  logic rv_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      chk("ready_vs_busy", 64'(bus.req_ready),
          64'(!bus.busy));
      if (bus.rsp_valid && sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rsp: rsp_valid=1 mul_rd=%0h none pending",
                 bus.mul_rd);
      end else if (bus.rsp_valid && !rv_prev) begin
        chk("latency", 64'(cyc - acc_cyc), 64'(sb[0].lat));
      end
      if (bus.rsp_valid && bus.rsp_ready && sb.size() > 0) begin
        e = sb.pop_front();
        chk("product", 64'(bus.mul_rd), 64'(e.prod));
      end
    end
    rv_prev = rst ? 1'b0 : bus.rsp_valid;
  end

  task automatic issue(logic [N-1:0] a, logic [N-1:0] b,
                       logic [2*N-1:0] p, int lat, bit exp);
    int n = 0;
    while (!bus.req_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.req_ready) begin
      tests++;
      fails++;
      $display("FAIL req_ready_timeout: got 0 expected 1");
    end
    bus.rs1       = a;
    bus.rs2       = b;
    bus.req_valid = 1'b1;
    if (exp) sb.push_back('{p, lat});
    @(posedge clk);
    #1;
    acc_cyc       = cyc;
    bus.req_valid = 1'b0;
    bus.rs1       = ~a;
    bus.rs2       = ~b;
    chk("busy_after_accept", 64'(bus.busy), 64'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d pending expected 0",
               sb.size());
      sb.delete();
    end
  endtask

  task automatic chk_idle(string nm);
    chk({nm, "_req_ready"}, 64'(bus.req_ready), 64'd1);
    chk({nm, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
    chk({nm, "_busy"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    int n;
    bus.req_valid = 1'b0;
    bus.rs1       = '0;
    bus.rs2       = '0;
    bus.kill      = 1'b0;
    bus.rsp_ready = 1'b1;

    #12;
    chk_idle("reset");
    chk("reset_mul_rd", 64'(bus.mul_rd), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    issue(16'd3, 16'd5, 32'd15, ET ? 3 : 16, 1'b1);
    drain();
    issue(16'hFFFF, 16'hFFFF, 32'hFFFE0001, 16, 1'b1);
    drain();
    issue(16'h1234, 16'h0000, 32'd0, ET ? 1 : 16, 1'b1);
    drain();
    issue(16'd10, 16'h0004, 32'd40, ET ? 3 : 16, 1'b1);
    drain();
    issue(16'd1, 16'h8000, 32'h8000, 16, 1'b1);
    drain();

    bus.rsp_ready = 1'b0;
    issue(16'hABCD, 16'h0002, 32'h1579A, ET ? 2 : 16, 1'b1);
    n = 0;
    while (!bus.rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(bus.rsp_valid), 64'd1);
      chk("bp_data", 64'(bus.mul_rd), 64'h1579A);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk_idle("bp_release");
    chk("bp_popped", 64'(sb.size()), 64'd0);
    sb.delete();

    issue(16'h1111, 16'h2222, 32'd0, 0, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    bus.kill = 1'b1;
    @(posedge clk);
    #1;
    bus.kill = 1'b0;
    chk_idle("kill");
    repeat (20) @(posedge clk);
    #1;
    issue(16'd7, 16'd9, 32'd63, ET ? 4 : 16, 1'b1);
    drain();

    issue(16'h0055, 16'h0066, 32'd0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_idle("async_rst");
    chk("async_rst_mul_rd", 64'(bus.mul_rd), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    issue(16'd2, 16'd2, 32'd4, ET ? 2 : 16, 1'b1);
    drain();
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mul_seq_ctrl.md
# mul_seq_ctrl

Sequential shift-add multiplier controller that replaces the N-adder combinational `mul` array with a single 2N-bit adder that is reused once per cycle. It accepts an operand pair over a valid/ready request channel. It steps through one multiplier bit per clock and returns the 2N-bit product over a valid/ready response channel. It sits in the execute stage in place of the combinational multiplier, and the core sequencer stalls on `req_ready`/`rsp_valid`.

## Interface
- `N`, default 16: operand width; the product is 2N bits wide.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `req_valid`  in  1: operand pair presented.
- `req_ready`  out  1: controller can accept a request; high only in IDLE.
- `rs1`  in  N: multiplicand (unsigned).
- `rs2`  in  N: multiplier (unsigned).
- `kill`  in  1: synchronous abort of the in-flight operation.
- `rsp_valid`  out  1: `mul_rd` holds a valid product.
- `rsp_ready`  in  1: consumer accepts the product.
- `mul_rd`  out  2N: product `rs1*rs2`.
- `busy`  out  1: high in RUN or DONE.

## Operation
- States:
  - IDLE: `req_ready`=1.
  - RUN: one bit per edge.
  - DONE: `rsp_valid`=1.
- IDLE -> RUN when `req_valid & req_ready`. On that edge:
  - `mcand` (2N bits) <= zero-extended `rs1`.
  - `mplier` (N bits) <= `rs2`.
  - `acc` <= 0.
  - `cnt` <= 0.
- RUN, each edge:
  - `acc` <= `acc + (mplier[0] ? mcand : 0)` through the single adder instance.
  - `mcand` <= `mcand << 1`.
  - `mplier` <= `mplier >> 1`.
  - `cnt` <= `cnt + 1`.
- RUN -> DONE on the edge where `cnt == N-1`, after the final add.
- DONE:
  - `mul_rd` = `acc`, held stable while `rsp_valid & ~rsp_ready`.
  - DONE -> IDLE on `rsp_valid & rsp_ready`.
- Arithmetic:
  - Unsigned only.
  - `acc`, `mcand` and the adder are 2N bits wide; a carry out of bit 2N-1 cannot occur and is discarded.
  - `cnt` is `$clog2(N)` bits wide, with a minimum of 1.
- `kill` in RUN or DONE -> IDLE on the next edge. No response is produced, and `acc` is left as-is (don't-care). `kill` in IDLE has no effect. If `kill` and `rsp_ready` are both high in DONE, `kill` wins and the response is dropped.
- `req_valid` outside IDLE is ignored. No request is accepted on the same edge that a response completes; IDLE is always entered for at least one cycle.
- `rs1`/`rs2` are sampled only on the accept edge; later changes have no effect.

## Timing
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `busy`=0, `mul_rd`=0, `acc`/`mcand`/`mplier`/`cnt`=0.
- Reset asserted mid-operation returns to IDLE immediately (asynchronously), with all outputs at their reset values and no response.
- Latency: `rsp_valid` rises exactly N edges after the accept edge (N+1 edges with the IDLE cycle). It is 16 for N=16 without the config macro.
- Throughput: one product per N+2 cycles at best (accept, N RUN edges, response edge).
- `req_ready`, `rsp_valid` and `busy` decode from registered state only; there is no combinational path from inputs to outputs.

## Configuration
- `MUL_SEQ_EARLY_TERM_EN`:
  - Defined: RUN -> DONE also occurs on the edge where the post-shift `mplier` equals 0. Latency = (index of the highest set bit of `rs2`) + 1, minimum 1. For example, `rs2`=0 or `rs2`=1 takes 1 edge, and `rs2`=0x8000 takes 16.
  - Undefined: fixed N-edge latency regardless of operands.
- The product is identical in both builds.

## Structure
- Package `mul_pkg`:
  - `typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t`.
  - `localparam MUL_N_DEFAULT = 16`.
- Sub-module `mul_seq_adder #(W)`: a single W-bit combinational adder (`sum = a + b`), instantiated once with W=2N. It is the only adder in the block.

## Test plan
- N=16, `rs1`=3, `rs2`=5, `rsp_ready`=1 -> `mul_rd`=15, `rsp_valid` exactly 16 edges after accept, `req_ready` low throughout.
- `rs1`=0xFFFF, `rs2`=0xFFFF -> `mul_rd`=0xFFFE0001. `rs1`=0x1234, `rs2`=0 -> 0. Without the macro, both take 16 edges.
- Backpressure: product 0xABCD*0x0002=0x1579A, with `rsp_ready` held low 5 cycles -> `rsp_valid` and `mul_rd` stable for 5 cycles, then IDLE one edge after `rsp_ready`.
- `kill` pulsed at RUN `cnt`=7 -> IDLE next edge, `rsp_valid` never asserts; the next request 7*9 returns 63.
- `rst` asserted at RUN `cnt`=3 -> outputs at reset values immediately; after release, 2*2 returns 4.
- With `MUL_SEQ_EARLY_TERM_EN`:
  - `rs2`=0 -> `rsp_valid` 1 edge after accept, `mul_rd`=0.
  - `rs2`=0x0004, `rs1`=10 -> 3 edges, `mul_rd`=40.
  - `rs2`=0x8000, `rs1`=1 -> 16 edges, `mul_rd`=0x8000.
